// File: rtl/status_reg_pkg.sv
// Shared definitions for the 6502 status register: flag bit positions,
// flag-instruction and branch-condition encodings, and the reset P value.
package status_reg_pkg;

  localparam int unsigned P_C = 0;
  localparam int unsigned P_Z = 1;
  localparam int unsigned P_I = 2;
  localparam int unsigned P_D = 3;
  localparam int unsigned P_B = 4;
  localparam int unsigned P_1 = 5;
  localparam int unsigned P_V = 6;
  localparam int unsigned P_N = 7;

  localparam logic [7:0] RESET_P_DEFAULT = 8'h24;

  typedef enum logic [2:0] {
    FOP_CLC  = 3'd0,
    FOP_SEC  = 3'd1,
    FOP_CLI  = 3'd2,
    FOP_SEI  = 3'd3,
    FOP_CLV  = 3'd4,
    FOP_CLD  = 3'd5,
    FOP_SED  = 3'd6,
    FOP_NONE = 3'd7
  } flag_op_e;

  typedef enum logic [2:0] {
    BR_BPL = 3'd0,
    BR_BMI = 3'd1,
    BR_BVC = 3'd2,
    BR_BVS = 3'd3,
    BR_BCC = 3'd4,
    BR_BCS = 3'd5,
    BR_BNE = 3'd6,
    BR_BEQ = 3'd7
  } cond_e;

endpackage

// File: rtl/status_reg_branch_cond.sv
// Combinational branch-condition decode of a 6502 branch code against N/V/Z/C.
module branch_cond
  import status_reg_pkg::*;
(
  input  logic       n,
  input  logic       v,
  input  logic       z,
  input  logic       c,
  input  logic [2:0] cond,
  output logic       cond_true
);

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      BR_BPL: cond_true = ~n;
      BR_BMI: cond_true = n;
      BR_BVC: cond_true = ~v;
      BR_BVS: cond_true = v;
      BR_BCC: cond_true = ~c;
      BR_BCS: cond_true = c;
      BR_BNE: cond_true = ~z;
      BR_BEQ: cond_true = z;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/status_reg.sv
// 6502 processor-status register with ALU flag capture pipeline, stack
// load, BIT, flag ops, interrupt entry and branch evaluation. Optional
// decimal mode is enabled by defining DECIMAL_EN.
module status_reg
  import status_reg_pkg::*;
#(
  parameter logic [7:0] RESET_P = RESET_P_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rdy,
  input  logic       upd_valid,
  input  logic [3:0] upd_mask,
  input  logic       alu_n,
  input  logic       alu_v,
  input  logic       alu_z,
  input  logic       alu_c,
  input  logic       load_p,
  input  logic       bit_op,
  input  logic [7:0] din,
  input  logic [2:0] flag_op,
  input  logic       irq_entry,
  input  logic       php_b,
  input  logic [2:0] cond,
  output logic [7:0] p_out,
  output logic       ci_out,
  output logic       bcd_out,
  output logic       cond_true
);

  logic [7:0] p_q;
  logic [7:0] p_d;
  logic       pend;
  logic [3:0] pend_mask;
  logic       d_flag;

  // Sources applied lowest priority first so later writes win per flag.
  always_comb begin
    p_d = p_q;
    if (irq_entry) p_d[P_I] = 1'b1;
    case (flag_op)
      FOP_CLC: p_d[P_C] = 1'b0;
      FOP_SEC: p_d[P_C] = 1'b1;
      FOP_CLI: p_d[P_I] = 1'b0;
      FOP_SEI: p_d[P_I] = 1'b1;
      FOP_CLV: p_d[P_V] = 1'b0;
      FOP_CLD: p_d[P_D] = 1'b0;
      FOP_SED: p_d[P_D] = 1'b1;
      default: ;
    endcase
    if (bit_op) begin
      p_d[P_N] = din[7];
      p_d[P_V] = din[6];
    end
    if (pend) begin
      if (pend_mask[3]) p_d[P_N] = alu_n;
      if (pend_mask[2]) p_d[P_V] = alu_v;
      if (pend_mask[1]) p_d[P_Z] = alu_z;
      if (pend_mask[0]) p_d[P_C] = alu_c;
    end
    if (load_p) p_d = din;
    p_d[P_1] = 1'b1;
    p_d[P_B] = 1'b0;
`ifndef DECIMAL_EN
    p_d[P_D] = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_q       <= RESET_P;
      pend      <= 1'b0;
      pend_mask <= '0;
    end else if (rdy) begin
      p_q  <= p_d;
      pend <= upd_valid;
      if (upd_valid) pend_mask <= upd_mask;
    end
  end

`ifdef DECIMAL_EN
  assign d_flag = p_q[P_D];
`else
  assign d_flag = 1'b0;
`endif

  assign p_out   = {p_q[P_N], p_q[P_V], 1'b1, php_b, d_flag, p_q[P_I], p_q[P_Z], p_q[P_C]};
  assign ci_out  = p_q[P_C];
  assign bcd_out = d_flag;

  branch_cond u_branch_cond (
    .n         (p_q[P_N]),
    .v         (p_q[P_V]),
    .z         (p_q[P_Z]),
    .c         (p_q[P_C]),
    .cond      (cond),
    .cond_true (cond_true)
  );

endmodule
